// File: rtl/sha256_job_arbiter.sv
// ---------------------------------------------------------------------------
// sha256_pkg / sha256_job_arbiter
//
// Purpose
//   Shares one SHA-256 core among N_REQ requester agents with one job in
//   flight at a time. A round-robin search picks a requester's context, which
//   is latched and issued to the core. The arbiter then waits for the digest,
//   guarded by an optional watchdog, and returns the digest or a timeout error
//   to the requester that owns the job.
//
// Ports
//   clk, rst                      clock (posedge) / async active-low reset
//   req_vld/req_rdy/req_ctx       per-requester context handshake (rdy one-hot)
//   rsp_vld/rsp_rdy               per-requester result handshake (vld one-hot)
//   rsp_hash, rsp_err             shared result bus, qualified by rsp_vld
//   core_ctx_vld/rdy, core_ctx    context handshake towards the core
//   core_hash_vld/rdy, core_hash  digest handshake from the core
//   busy                          a job is in progress (state != IDLE)
//   owner                         requester index of the current job
//   timeout_err                   one-cycle pulse when the watchdog expires
//   jobs_done                     wrapping count of successful completions
// ---------------------------------------------------------------------------

package sha256_pkg;

    // Resumable hashing context: chaining state plus the next message block.
    typedef struct packed {
        logic [255:0] state;
        logic [511:0] block;
    } ShaContext;

endpackage : sha256_pkg


module sha256_job_arbiter #(
    parameter  int N_REQ       = 4,
    parameter  int TIMEOUT_CYC = 4096,
    localparam int IDW         = $clog2(N_REQ)
) (
    input  logic                                clk,
    input  logic                                rst,

    input  logic [N_REQ-1:0]                    req_vld,
    output logic [N_REQ-1:0]                    req_rdy,
    input  sha256_pkg::ShaContext [N_REQ-1:0]   req_ctx,

    output logic [N_REQ-1:0]                    rsp_vld,
    input  logic [N_REQ-1:0]                    rsp_rdy,
    output logic [255:0]                        rsp_hash,
    output logic                                rsp_err,

    output logic                                core_ctx_vld,
    input  logic                                core_ctx_rdy,
    output sha256_pkg::ShaContext               core_ctx,

    input  logic                                core_hash_vld,
    output logic                                core_hash_rdy,
    input  logic [255:0]                        core_hash,

    output logic                                busy,
    output logic [IDW-1:0]                      owner,
    output logic                                timeout_err,
    output logic [15:0]                         jobs_done
);

    // Watchdog is sized to hold TIMEOUT_CYC; a disabled watchdog keeps one
    // dummy bit so no zero-width vector is ever declared.
    localparam bit      WD_EN  = (TIMEOUT_CYC > 0);
    localparam int      WD_W   = WD_EN ? $clog2(TIMEOUT_CYC + 1) : 1;
    localparam [WD_W-1:0] WD_EXP = WD_EN ? WD_W'(TIMEOUT_CYC - 1) : '0;
    localparam [WD_W-1:0] WD_MAX = '1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_RETURN
    } state_t;

    state_t                 r_state;
    state_t                 w_state_nxt;

    sha256_pkg::ShaContext  r_ctx;
    logic [IDW-1:0]         r_owner;
    logic [IDW-1:0]         r_last;
    logic [255:0]           r_hash;
    logic                   r_err;
    logic [WD_W-1:0]        r_wd;
    logic [15:0]            r_jobs;

    logic                   w_gnt_any;
    logic [IDW-1:0]         w_gnt_idx;
    int                     w_idx;
    logic [N_REQ-1:0]       w_gnt_onehot;
    logic [N_REQ-1:0]       w_owner_onehot;
    logic                   w_expired;

    // Control strobes from the FSM to the datapath registers.
    logic                   w_take_req;
    logic                   w_ctx_acc;
    logic                   w_wd_inc;
    logic                   w_hash_ok;
    logic                   w_hash_to;
    logic                   w_rsp_done;

    // -----------------------------------------------------------------------
    // Round-robin search: candidates are last+1, last+2, ... (mod N_REQ).
    // The loop walks from the farthest candidate to the nearest so the last
    // hit written is the highest-priority one.
    // -----------------------------------------------------------------------
    // NOTE: every signal driven in an always_comb gets a default first, so no
    // path through the block leaves it unassigned and no latch is inferred.
    always_comb begin
        w_gnt_any = 1'b0;
        w_gnt_idx = '0;
        w_idx     = 0;
        for (int k = N_REQ; k >= 1; k--) begin
            w_idx = (int'(r_last) + k) % N_REQ;
            if (req_vld[w_idx]) begin
                w_gnt_any = 1'b1;
                w_gnt_idx = w_idx[IDW-1:0];
            end
        end
    end

    assign w_gnt_onehot   = {{(N_REQ-1){1'b0}}, 1'b1} << w_gnt_idx;
    assign w_owner_onehot = {{(N_REQ-1){1'b0}}, 1'b1} << r_owner;
    assign w_expired      = WD_EN && (r_wd == WD_EXP);

    // -----------------------------------------------------------------------
    // FSM state register
    // -----------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of process evaluation order.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // -----------------------------------------------------------------------
    // FSM next state and outputs.
    // req_rdy and core_hash_rdy are gated by rst so that every output reads 0
    // while reset is held, even though the reset state is IDLE.
    // -----------------------------------------------------------------------
    always_comb begin
        w_state_nxt   = r_state;
        req_rdy       = '0;
        rsp_vld       = '0;
        core_ctx_vld  = 1'b0;
        core_hash_rdy = 1'b0;
        timeout_err   = 1'b0;
        w_take_req    = 1'b0;
        w_ctx_acc     = 1'b0;
        w_wd_inc      = 1'b0;
        w_hash_ok     = 1'b0;
        w_hash_to     = 1'b0;
        w_rsp_done    = 1'b0;

        case (r_state)
            S_IDLE: begin
                // A digest arriving here is stale; it is accepted and dropped.
                core_hash_rdy = rst;
                if (w_gnt_any) begin
                    req_rdy     = rst ? w_gnt_onehot : '0;
                    w_take_req  = 1'b1;
                    w_state_nxt = S_ISSUE;
                end
            end

            S_ISSUE: begin
                core_hash_rdy = 1'b1;
                core_ctx_vld  = 1'b1;
                if (core_ctx_rdy) begin
                    w_ctx_acc   = 1'b1;
                    w_state_nxt = S_WAIT;
                end
            end

            S_WAIT: begin
                core_hash_rdy = 1'b1;
                w_wd_inc      = 1'b1;
                // A digest on the expiry cycle wins over the timeout.
                if (core_hash_vld) begin
                    w_hash_ok   = 1'b1;
                    w_state_nxt = S_RETURN;
                end else if (w_expired) begin
                    w_hash_to   = 1'b1;
                    timeout_err = 1'b1;
                    w_state_nxt = S_RETURN;
                end
            end

            S_RETURN: begin
                rsp_vld = w_owner_onehot;
                // Only the owner's rsp_rdy completes the job.
                if (rsp_rdy[r_owner]) begin
                    w_rsp_done  = 1'b1;
                    w_state_nxt = S_IDLE;
                end
            end

            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // -----------------------------------------------------------------------
    // Datapath registers
    // -----------------------------------------------------------------------
    // NOTE: the wide context and digest registers are reset explicitly; they
    // drive outputs directly, so they must read 0 while reset is held.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_ctx   <= '0;
            r_owner <= '0;
            r_last  <= IDW'(N_REQ - 1);
            r_hash  <= '0;
            r_err   <= 1'b0;
            r_wd    <= '0;
            r_jobs  <= '0;
        end else begin
            if (w_take_req) begin
                r_ctx   <= req_ctx[w_gnt_idx];
                r_owner <= w_gnt_idx;
            end

            if (w_ctx_acc) begin
                r_wd <= '0;
            end else if (w_wd_inc && (r_wd != WD_MAX)) begin
                r_wd <= r_wd + 1'b1;
            end

            if (w_hash_ok) begin
                r_hash <= core_hash;
                r_err  <= 1'b0;
            end else if (w_hash_to) begin
                r_hash <= '0;
                r_err  <= 1'b1;
            end

            if (w_rsp_done) begin
                r_last <= r_owner;
                if (!r_err) begin
                    r_jobs <= r_jobs + 16'd1;
                end
            end
        end
    end

    assign core_ctx  = r_ctx;
    assign rsp_hash  = r_hash;
    assign rsp_err   = r_err;
    assign busy      = (r_state != S_IDLE);
    assign owner     = r_owner;
    assign jobs_done = r_jobs;

endmodule : sha256_job_arbiter

// File: tb/tb_sha256_job_arbiter.sv
// ---------------------------------------------------------------------------
// tb_sha256_job_arbiter
//
// Directed bench for sha256_job_arbiter (N_REQ=4, TIMEOUT_CYC=16). Inputs are
// driven 1 ns after the rising edge and outputs are sampled 1 ns later, well
// away from the next edge. Expected values are hand-derived constants and a
// running count of successful jobs.
// ---------------------------------------------------------------------------

module tb_sha256_job_arbiter;

    localparam int N_REQ = 4;
    localparam int TO    = 16;

    logic                               clk;
    logic                               rst;
    logic [N_REQ-1:0]                   req_vld;
    logic [N_REQ-1:0]                   req_rdy;
    sha256_pkg::ShaContext [N_REQ-1:0]  req_ctx;
    logic [N_REQ-1:0]                   rsp_vld;
    logic [N_REQ-1:0]                   rsp_rdy;
    logic [255:0]                       rsp_hash;
    logic                               rsp_err;
    logic                               core_ctx_vld;
    logic                               core_ctx_rdy;
    sha256_pkg::ShaContext              core_ctx;
    logic                               core_hash_vld;
    logic                               core_hash_rdy;
    logic [255:0]                       core_hash;
    logic                               busy;
    logic [1:0]                         owner;
    logic                               timeout_err;
    logic [15:0]                        jobs_done;

    int n_checks = 0;
    int n_fail   = 0;
    int exp_jobs = 0;

    localparam logic [255:0] HASH_A    = {16'hDEAD, 224'h0, 16'hBEEF};
    localparam logic [255:0] HASH_B    = {64'h0123_4567_89AB_CDEF, 192'h5A5A};
    localparam logic [255:0] HASH_C    = {128'hC0FFEE, 128'hFACE_CAFE};
    localparam logic [255:0] HASH_T    = {8{32'h1357_9BDF}};
    localparam logic [255:0] HASH_D    = {4{64'hD00D_F00D_0BAD_F00D}};
    localparam logic [255:0] HASH_LATE = {8{32'hBAAD_BAAD}};

    sha256_job_arbiter #(
        .N_REQ       (N_REQ),
        .TIMEOUT_CYC (TO)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .req_vld       (req_vld),
        .req_rdy       (req_rdy),
        .req_ctx       (req_ctx),
        .rsp_vld       (rsp_vld),
        .rsp_rdy       (rsp_rdy),
        .rsp_hash      (rsp_hash),
        .rsp_err       (rsp_err),
        .core_ctx_vld  (core_ctx_vld),
        .core_ctx_rdy  (core_ctx_rdy),
        .core_ctx      (core_ctx),
        .core_hash_vld (core_hash_vld),
        .core_hash_rdy (core_hash_rdy),
        .core_hash     (core_hash),
        .busy          (busy),
        .owner         (owner),
        .timeout_err   (timeout_err),
        .jobs_done     (jobs_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Hard stop in case the sequence ever stalls.
    initial begin
        #200000;
        $display("FAIL global_timeout observed=stalled expected=finished");
        $fatal(1, "bench did not finish");
    end

    function automatic sha256_pkg::ShaContext mk_ctx(input int i);
        sha256_pkg::ShaContext c;
        c.state = {8{32'h6A09_E667 + 32'(i)}};
        c.block = {16{32'h1000_0000 * 32'(i) + 32'h5}};
        return c;
    endfunction

    task automatic check(input string tag, input logic [767:0] obs, input logic [767:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    // Full job: grant, issue with immediate accept, digest in WAIT cycle
    // (wait_cycles+1), response taken immediately.
    task automatic do_job(input logic [3:0] mask, input int exp_owner,
                          input logic [255:0] hash, input int wait_cycles);
        req_vld = mask;
        settle();
        check("job_req_rdy", 768'(req_rdy), 768'(4'b0001 << exp_owner));
        cyc();
        settle();
        check("job_issue_vld", 768'(core_ctx_vld), 768'(1'b1));
        check("job_owner", 768'(owner), 768'(exp_owner));
        check("job_core_ctx", 768'(core_ctx), 768'(mk_ctx(exp_owner)));
        check("job_no_rdy_busy", 768'(req_rdy), 768'(4'b0000));
        core_ctx_rdy = 1'b1;
        cyc();
        core_ctx_rdy = 1'b0;
        repeat (wait_cycles) cyc();
        core_hash_vld = 1'b1;
        core_hash     = hash;
        settle();
        check("job_hash_rdy", 768'(core_hash_rdy), 768'(1'b1));
        check("job_no_timeout", 768'(timeout_err), 768'(1'b0));
        cyc();
        core_hash_vld = 1'b0;
        core_hash     = '0;
        settle();
        check("job_rsp_vld", 768'(rsp_vld), 768'(4'b0001 << exp_owner));
        check("job_rsp_hash", 768'(rsp_hash), 768'(hash));
        check("job_rsp_err", 768'(rsp_err), 768'(1'b0));
        check("job_ret_hash_rdy", 768'(core_hash_rdy), 768'(1'b0));
        rsp_rdy = 4'b0001 << exp_owner;
        cyc();
        rsp_rdy = '0;
        exp_jobs++;
        settle();
        check("job_idle", 768'(busy), 768'(1'b0));
        check("job_jobs_done", 768'(jobs_done), 768'(exp_jobs));
    endtask

    task automatic do_reset();
        rst = 1'b0;
        exp_jobs = 0;
        repeat (2) cyc();
        rst = 1'b1;
        settle();
    endtask

    initial begin
        rst           = 1'b0;
        req_vld       = '0;
        rsp_rdy       = '0;
        core_ctx_rdy  = 1'b0;
        core_hash_vld = 1'b0;
        core_hash     = '0;
        for (int i = 0; i < N_REQ; i++) req_ctx[i] = mk_ctx(i);

        // ---------------- reset state ----------------
        #2;
        check("rst_busy", 768'(busy), 768'(1'b0));
        check("rst_req_rdy", 768'(req_rdy), 768'(4'b0000));
        check("rst_rsp_vld", 768'(rsp_vld), 768'(4'b0000));
        check("rst_ctx_vld", 768'(core_ctx_vld), 768'(1'b0));
        check("rst_hash_rdy", 768'(core_hash_rdy), 768'(1'b0));
        check("rst_core_ctx", 768'(core_ctx), 768'(0));
        check("rst_rsp_hash", 768'(rsp_hash), 768'(0));
        check("rst_jobs", 768'(jobs_done), 768'(0));
        check("rst_timeout", 768'(timeout_err), 768'(1'b0));
        do_reset();
        check("idle_hash_rdy", 768'(core_hash_rdy), 768'(1'b1));

        // ---------------- single job, requester 2, 10-cycle core ----------
        do_job(4'b0100, 2, HASH_A, 9);
        req_vld = '0;
        settle();
        check("single_jobs_one", 768'(jobs_done), 768'(16'd1));

        // ---------------- round robin from reset ----------------
        do_reset();
        do_job(4'b1111, 0, HASH_A, 2);
        do_job(4'b1111, 1, HASH_B, 2);
        do_job(4'b1111, 2, HASH_C, 2);
        do_job(4'b1111, 3, HASH_D, 2);
        do_job(4'b1111, 0, HASH_T, 2);
        // last = 0

        // ---------------- backpressure, requester 1 ----------------
        req_vld = 4'b0010;
        settle();
        check("bp_req_rdy", 768'(req_rdy), 768'(4'b0010));
        cyc();
        req_vld = 4'b1111;
        for (int i = 0; i < 7; i++) begin
            settle();
            check("bp_ctx_vld", 768'(core_ctx_vld), 768'(1'b1));
            check("bp_ctx_stable", 768'(core_ctx), 768'(mk_ctx(1)));
            check("bp_issue_no_rdy", 768'(req_rdy), 768'(4'b0000));
            cyc();
        end
        core_ctx_rdy = 1'b1;
        cyc();
        core_ctx_rdy = 1'b0;
        repeat (3) cyc();
        core_hash_vld = 1'b1;
        core_hash     = HASH_B;
        cyc();
        core_hash_vld = 1'b0;
        core_hash     = HASH_LATE;  // must not disturb the held result
        rsp_rdy       = 4'b1101;    // non-owners' ready is ignored
        for (int i = 0; i < 5; i++) begin
            settle();
            check("bp_rsp_vld", 768'(rsp_vld), 768'(4'b0010));
            check("bp_rsp_hash", 768'(rsp_hash), 768'(HASH_B));
            check("bp_ret_no_rdy", 768'(req_rdy), 768'(4'b0000));
            check("bp_busy", 768'(busy), 768'(1'b1));
            cyc();
        end
        rsp_rdy = 4'b0010;
        cyc();
        rsp_rdy = '0;
        exp_jobs++;
        settle();
        check("bp_jobs", 768'(jobs_done), 768'(exp_jobs));
        check("bp_next_grant", 768'(req_rdy), 768'(4'b0100));
        req_vld = '0;
        settle();
        check("bp_idle_no_rdy", 768'(req_rdy), 768'(4'b0000));
        // last = 1

        // ---------------- timeout, requester 0 ----------------
        req_vld = 4'b0001;
        settle();
        check("to_req_rdy", 768'(req_rdy), 768'(4'b0001));
        cyc();
        req_vld      = '0;
        core_ctx_rdy = 1'b1;
        cyc();
        core_ctx_rdy = 1'b0;
        for (int i = 1; i <= TO - 1; i++) begin
            settle();
            check("to_early_pulse", 768'(timeout_err), 768'(1'b0));
            cyc();
        end
        settle();
        check("to_pulse", 768'(timeout_err), 768'(1'b1));
        cyc();
        settle();
        check("to_pulse_end", 768'(timeout_err), 768'(1'b0));
        check("to_rsp_vld", 768'(rsp_vld), 768'(4'b0001));
        check("to_rsp_err", 768'(rsp_err), 768'(1'b1));
        check("to_rsp_hash", 768'(rsp_hash), 768'(0));
        rsp_rdy = 4'b0001;
        cyc();
        rsp_rdy = '0;
        settle();
        check("to_jobs_same", 768'(jobs_done), 768'(exp_jobs));
        check("to_idle", 768'(busy), 768'(1'b0));
        // late digest in IDLE is consumed and dropped
        core_hash_vld = 1'b1;
        core_hash     = HASH_LATE;
        settle();
        check("late_hash_rdy", 768'(core_hash_rdy), 768'(1'b1));
        cyc();
        core_hash_vld = 1'b0;
        settle();
        check("late_still_idle", 768'(busy), 768'(1'b0));
        check("late_no_rsp", 768'(rsp_vld), 768'(4'b0000));
        do_job(4'b0001, 0, HASH_C, 4);

        // ---------------- tie: digest on expiry cycle ----------------
        do_job(4'b1000, 3, HASH_T, TO - 1);
        // last = 3

        // ---------------- async reset in WAIT ----------------
        req_vld = 4'b1111;
        settle();
        check("ar_req_rdy", 768'(req_rdy), 768'(4'b0001));
        cyc();
        core_ctx_rdy = 1'b1;
        cyc();
        core_ctx_rdy = 1'b0;
        repeat (3) cyc();
        settle();
        check("ar_busy_before", 768'(busy), 768'(1'b1));
        rst = 1'b0;
        exp_jobs = 0;
        #1;
        check("ar_busy", 768'(busy), 768'(1'b0));
        check("ar_req_rdy_zero", 768'(req_rdy), 768'(4'b0000));
        check("ar_hash_rdy", 768'(core_hash_rdy), 768'(1'b0));
        check("ar_ctx_vld", 768'(core_ctx_vld), 768'(1'b0));
        check("ar_core_ctx", 768'(core_ctx), 768'(0));
        check("ar_rsp_vld", 768'(rsp_vld), 768'(4'b0000));
        check("ar_owner", 768'(owner), 768'(0));
        check("ar_jobs", 768'(jobs_done), 768'(0));
        cyc();
        rst = 1'b1;
        settle();
        check("ar_first_grant", 768'(req_rdy), 768'(4'b0001));
        do_job(4'b1111, 0, HASH_D, 2);
        req_vld = '0;

        repeat (2) cyc();
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule : tb_sha256_job_arbiter
